// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped I/O controller.
// Default address map and button register field positions.
package mmio_pkg;
    localparam int ADDR_W_DEF      = 12;
    localparam int DATA_W_DEF      = 32;
    localparam int CH_BASE_DEF     = 300;
    localparam int CH_STRIDE_DEF   = 100;
    localparam int BTN_ADDR_DEF    = 0;
    localparam int DONE_ADDR_DEF   = 1;
    localparam int COMMIT_ADDR_DEF = 2;
    localparam int BTN_LVL_LSB     = 0;
    localparam int BTN_EVT_LSB     = 16;
endpackage

// File: rtl/mmio_ctrl_btn_sync_edge.sv
// Button synchroniser with rising-edge event latch (W1C, set wins).
// Event logic is present only when MMIO_BTN_EDGE_EN is defined.
module btn_sync_edge #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_btn,
    input  logic [W-1:0] i_clr,
    output logic [W-1:0] o_lvl,
    output logic [W-1:0] o_evt
);
    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

    assign o_lvl = r_s2;

`ifdef MMIO_BTN_EDGE_EN
    logic [W-1:0] r_s3;
    logic [W-1:0] r_evt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s3  <= '0;
            r_evt <= '0;
        end else begin
            r_s3  <= r_s2;
            r_evt <= (r_evt & ~i_clr) | (r_s2 & ~r_s3);
        end
    end

    assign o_evt = r_evt;
`else
    logic [W-1:0] w_unused_clr;
    assign w_unused_clr = i_clr;
    assign o_evt        = '0;
`endif
endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller: address decode, double-buffered channels, done flag, buttons.
// Define MMIO_BTN_EDGE_EN to include the button edge-event register.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NUM_CH      = 4,
    parameter int CH_BASE     = CH_BASE_DEF,
    parameter int CH_STRIDE   = CH_STRIDE_DEF,
    parameter int BTN_W       = 3,
    parameter int BTN_ADDR    = BTN_ADDR_DEF,
    parameter int DONE_ADDR   = DONE_ADDR_DEF,
    parameter int COMMIT_ADDR = COMMIT_ADDR_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wren,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W-1:0]        ram_q,
    output logic [DATA_W-1:0]        q,
    output logic                     ram_wren,
    input  logic [BTN_W-1:0]         btn_in,
    output logic [NUM_CH*DATA_W-1:0] ch_out,
    output logic                     frame_valid,
    output logic                     done
);
    logic [DATA_W-1:0] r_shadow [NUM_CH];
    logic [DATA_W-1:0] r_active [NUM_CH];
    logic              r_done;
    logic              r_fv;

    logic              w_btn_hit;
    logic              w_done_hit;
    logic              w_commit_hit;
    logic [NUM_CH-1:0] w_ch_hit;
    logic              w_io_hit;
    logic [BTN_W-1:0]  w_lvl;
    logic [BTN_W-1:0]  w_evt;
    logic [BTN_W-1:0]  w_clr;
    logic [DATA_W-1:0] w_ch_rd;
    logic [DATA_W-1:0] w_btn_word;

    assign w_btn_hit    = (addr == ADDR_W'(BTN_ADDR));
    assign w_done_hit   = (addr == ADDR_W'(DONE_ADDR));
    assign w_commit_hit = (addr == ADDR_W'(COMMIT_ADDR));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [ADDR_W-1:0] LP_A = ADDR_W'(CH_BASE + k * CH_STRIDE);
        assign w_ch_hit[k] = (addr == LP_A);
        assign ch_out[k*DATA_W +: DATA_W] = r_active[k];
    end

    assign w_io_hit    = w_btn_hit | w_done_hit | w_commit_hit | (|w_ch_hit);
    assign ram_wren    = wren & ~w_io_hit;
    assign frame_valid = r_fv;
    assign done        = r_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shadow <= '{default: '0};
            r_active <= '{default: '0};
            r_done   <= 1'b0;
            r_fv     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wren && w_ch_hit[i]) begin
                    r_shadow[i] <= wdata;
                end
            end
            // All channels flip together so the display never sees a half frame.
            if (wren && w_commit_hit) begin
                r_active <= r_shadow;
            end
            if (wren && w_done_hit && wdata[0]) begin
                r_done <= 1'b1;
            end
            r_fv <= wren & w_commit_hit;
        end
    end

    assign w_clr = (wren && w_btn_hit) ? wdata[BTN_EVT_LSB +: BTN_W] : '0;

    btn_sync_edge #(
        .W(BTN_W)
    ) u_btn (
        .i_clk  (clock),
        .i_rst_n(reset),
        .i_btn  (btn_in),
        .i_clr  (w_clr),
        .o_lvl  (w_lvl),
        .o_evt  (w_evt)
    );

    always_comb begin
        w_ch_rd    = '0;
        w_btn_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_hit[i]) begin
                w_ch_rd = w_ch_rd | r_shadow[i];
            end
        end
        w_btn_word[BTN_LVL_LSB +: BTN_W] = w_lvl;
        w_btn_word[BTN_EVT_LSB +: BTN_W] = w_evt;
    end

    always_comb begin
        q = ram_q;
        unique case (1'b1)
            w_btn_hit:    q = w_btn_word;
            w_done_hit:   q = {{(DATA_W-1){1'b0}}, r_done};
            w_commit_hit: q = '0;
            (|w_ch_hit):  q = w_ch_rd;
            default:      q = ram_q;
        endcase
    end
endmodule

// File: doc/mmio_ctrl.md
# mmio_ctrl

Parametrised memory-mapped I/O controller between the processor's data-memory port and the RAM and peripherals. It decodes the 12-bit data address and gates RAM writes away from I/O addresses. It holds NUM_CH double-buffered output channels (sprite coordinates and similar) that are committed atomically to the display logic, and provides a sticky game-done flag. It also synchronises the push buttons and latches their rising edges, cleared by write-1-to-clear.

## Interface
Parameters:
- ADDR_W, 12, data address width
- DATA_W, 32, data word width
- NUM_CH, 4, number of output channels (1..8)
- CH_BASE, 300, address of channel 0
- CH_STRIDE, 100, address step between channels
- BTN_W, 3, button input width (≤ 16)
- BTN_ADDR, 0, button status/clear register
- DONE_ADDR, 1, sticky done flag
- COMMIT_ADDR, 2, shadow-to-active commit strobe

Ports:
- clock  input  1  single clock; all state on posedge
- reset  input  1  asynchronous, active-low reset
- wren  input  1  processor data write enable
- addr  input  ADDR_W  processor data address
- wdata  input  DATA_W  processor write data
- ram_q  input  DATA_W  RAM read data
- q  output  DATA_W  read data returned to processor (combinational mux)
- ram_wren  output  1  RAM write enable = wren && !io_hit
- btn_in  input  BTN_W  raw asynchronous buttons
- ch_out  output  NUM_CH*DATA_W  active channel values, channel k at bits [k*DATA_W +: DATA_W]
- frame_valid  output  1  one-cycle pulse after each commit
- done  output  1  sticky game-done flag

## Operation
- io_hit: addr equals BTN_ADDR, DONE_ADDR, COMMIT_ADDR, or CH_BASE + k*CH_STRIDE for any k < NUM_CH. Address constants must be distinct; any overlap is a configuration error.
- Channel write (wren, addr = ch k): shadow[k] <= wdata. Active ch_out is unchanged.
- Commit write (wren, addr = COMMIT_ADDR, any data): active[k] <= shadow[k] for all k in the same edge. frame_valid is registered and asserts on the following cycle for exactly one cycle. Back-to-back commits give consecutive pulses. A commit with unchanged shadows still pulses.
- Done write (wren, addr = DONE_ADDR): if wdata[0] = 1, done <= 1. Writing 0 has no effect. Only reset clears done.
- Buttons: 2-flop synchroniser per bit → sync level. A rising edge of the sync level sets evt[i].
- Button write (wren, addr = BTN_ADDR): evt[i] cleared where wdata[16+i] = 1. If a new edge arrives on the same cycle as its clear, set wins.
- Reads, combinational, decoded on addr regardless of wren:
  - BTN_ADDR → {evt zero-extended in [31:16], sync level zero-extended in [15:0]}
  - DONE_ADDR → {31'b0, done}
  - ch k → shadow[k]
  - COMMIT_ADDR → 0
  - otherwise → ram_q
- All state is zero on reset: shadow, active, ch_out, evt, sync flops, done, frame_valid.

## Timing
- Register writes take effect at the clock edge where wren is high. q reflects the new value combinationally from the next cycle.
- Commit latency: write edge N → ch_out updated after edge N; frame_valid high during cycle N+1.
- Button latency: btn_in change → sync level visible 2 edges later → evt set on the 3rd edge.
- Asynchronous reset mid-frame: outputs go to zero immediately. A pending frame_valid pulse is dropped.
- Reset deassertion is synchronised externally; the block assumes clean release.

## Configuration
- MMIO_BTN_EDGE_EN defined: edge detection and evt register present as above.
- Undefined: no evt register. BTN_ADDR reads return the sync level in [15:0] with [31:16] = 0. Writes to BTN_ADDR are ignored, but BTN_ADDR still counts as io_hit.

## Structure
- Package mmio_pkg: default address constants, DATA_W and ADDR_W defaults, bit-field positions of the button register (level LSB 0, event LSB 16).
- Sub-module btn_sync_edge: per-bit 2-flop synchroniser, rising-edge detect, set/W1C event latch with set priority.

## Test plan
- Reset: hold reset low, write every I/O address → ch_out = 0, done = 0, frame_valid = 0, q at BTN_ADDR = 0.
- Double buffering: write 0x55 to addr 300 and 0xAA to addr 400 → ch_out unchanged and q at 300 = 0x55. Then write COMMIT_ADDR → ch0 = 0x55, ch1 = 0xAA, frame_valid high exactly one cycle.
- RAM gating: write 0x1234 to addr 5 → ram_wren = 1. Write to addr 300 → ram_wren = 0. Read addr 5 returns ram_q; read addr 300 ignores ram_q.
- Done sticky: write 0 to DONE_ADDR → done = 0. Write 1 → done = 1. Write 0 → done stays 1 until reset.
- Buttons with MMIO_BTN_EDGE_EN: pulse btn_in[1] → q[17] = 1 on the 3rd edge and remains set after release. Write 0x00020000 to BTN_ADDR → q[17] = 0. Clear on the same cycle as a new edge → q[17] stays 1.
- Buttons without MMIO_BTN_EDGE_EN: hold btn_in = 3'b101 → q = 0x5 after 2 edges. Release → q = 0 after 2 edges.
